cdb_arbiter_queued: RTL and testbench

//  Parametrised successor to the fixed FU->CDB select stage. Every FU result producer gets a

---
 rtl/sys_defs.sv | 28 ++
 rtl/cdb_result_queue.sv | 74 +++++++
 rtl/cdb_arbiter_queued.sv | 130 +++++++++++++
 tb/tb_cdb_arbiter_queued.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_defs.sv
// Shared CDB definitions: lane/packet layout and default widths.
// Also provides the pointer-width helper used by the arbiter and queues.
package sys_defs;

  localparam int DEF_NUM_REQ     = 6;
  localparam int DEF_CDB_WIDTH   = 3;
  localparam int DEF_QUEUE_DEPTH = 2;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_PRN_W       = 6;
  localparam int DEF_ROBN_W      = 5;

  typedef struct packed {
    logic                  valid;
    logic [DEF_PRN_W-1:0]  prn;
    logic [DEF_DATA_W-1:0] value;
    logic [DEF_ROBN_W-1:0] robn;
  } cdb_lane_t;

  typedef cdb_lane_t [DEF_CDB_WIDTH-1:0] cdb_packet_t;

  // Width of an index into n items, never below one bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_RR_W = ptr_w(DEF_NUM_REQ);

endpackage

// File: rtl/cdb_result_queue.sv
// Single-producer result FIFO with occupancy count and flush.
// Ready depends only on the registered count, never on a same-cycle pop.
module cdb_result_queue
  import sys_defs::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         ready,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok;
  logic          pop_ok;

  assign ready = (count_q != CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[head_q];

  // Next queue state: flush wins, else push at tail and pop at head.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    push_ok = push & ready;
    pop_ok  = pop & ~empty;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_ok) begin
        mem_d[tail_q] = din;
        tail_d        = tail_q + PW'(1);
      end
      if (pop_ok) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Queue state register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/cdb_arbiter_queued.sv
// Queued FU->CDB arbiter: per-producer FIFOs, rotating multi-grant
// selection of up to CDB_WIDTH heads, lane packing and stall counter.
module cdb_arbiter_queued #(
  parameter int NUM_REQ     = sys_defs::DEF_NUM_REQ,
  parameter int CDB_WIDTH   = sys_defs::DEF_CDB_WIDTH,
  parameter int QUEUE_DEPTH = sys_defs::DEF_QUEUE_DEPTH,
  parameter int DATA_W      = sys_defs::DEF_DATA_W,
  parameter int PRN_W       = sys_defs::DEF_PRN_W,
  parameter int ROBN_W      = sys_defs::DEF_ROBN_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        squash,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*PRN_W-1:0]    req_prn,
  input  logic [NUM_REQ*DATA_W-1:0]   req_value,
  input  logic [NUM_REQ*ROBN_W-1:0]   req_robn,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [CDB_WIDTH-1:0]        cdb_valid,
  output logic [CDB_WIDTH*PRN_W-1:0]  cdb_prn,
  output logic [CDB_WIDTH*DATA_W-1:0] cdb_value,
  output logic [CDB_WIDTH*ROBN_W-1:0] cdb_robn,
  output logic [31:0]                 stall_count
);

  import sys_defs::*;

  localparam int RR_W = ptr_w(NUM_REQ);
  localparam int IX_W = RR_W + 1;
  localparam int LC_W = $clog2(CDB_WIDTH + 1);

  typedef struct packed {
    logic [PRN_W-1:0]  prn;
    logic [DATA_W-1:0] value;
    logic [ROBN_W-1:0] robn;
  } ent_t;

  ent_t                 din    [NUM_REQ];
  ent_t                 head   [NUM_REQ];
  ent_t                 lane_e [CDB_WIDTH];
  logic [CDB_WIDTH-1:0] lane_v;
  logic [NUM_REQ-1:0]   q_empty;
  logic [NUM_REQ-1:0]   grant;
  logic [LC_W-1:0]      n_gnt;
  logic [IX_W-1:0]      idx;
  logic [RR_W-1:0]      last;
  logic [RR_W-1:0]      rr_q, rr_d;
  logic [31:0]          stall_q, stall_d;
  logic                 stall;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_q
    assign din[i].prn   = req_prn[i*PRN_W +: PRN_W];
    assign din[i].value = req_value[i*DATA_W +: DATA_W];
    assign din[i].robn  = req_robn[i*ROBN_W +: ROBN_W];

    cdb_result_queue #(
      .DEPTH(QUEUE_DEPTH),
      .W    ($bits(ent_t))
    ) u_q (
      .clock(clock),
      .reset(reset),
      .flush(squash),
      .push (req_valid[i]),
      .pop  (grant[i]),
      .din  (din[i]),
      .ready(req_ready[i]),
      .empty(q_empty[i]),
      .head (head[i])
    );
  end

  // Scan queues from rr_q, grant the first CDB_WIDTH non-empty heads.
  always_comb begin
    grant  = '0;
    lane_v = '0;
    lane_e = '{default: '0};
    n_gnt  = '0;
    last   = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_q} + IX_W'(k);
      if (idx >= IX_W'(NUM_REQ)) begin
        idx = idx - IX_W'(NUM_REQ);
      end
      if (!q_empty[idx[RR_W-1:0]] && (n_gnt < LC_W'(CDB_WIDTH))) begin
        grant[idx[RR_W-1:0]] = 1'b1;
        lane_v[n_gnt]        = 1'b1;
        lane_e[n_gnt]        = head[idx[RR_W-1:0]];
        last                 = idx[RR_W-1:0];
        n_gnt                = n_gnt + LC_W'(1);
      end
    end
  end

  // Rotate priority past the last grant; count ungranted backlog.
  always_comb begin
    rr_d    = rr_q;
    stall_d = stall_q;
    stall   = |(~q_empty & ~grant);
    if (!squash) begin
      if (|grant) begin
        rr_d = (last == RR_W'(NUM_REQ - 1)) ? '0 : last + RR_W'(1);
      end
      if (stall && (stall_q != '1)) begin
        stall_d = stall_q + 32'd1;
      end
    end
  end

  // Priority pointer and stall counter registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_q    <= '0;
      stall_q <= '0;
    end else begin
      rr_q    <= rr_d;
      stall_q <= stall_d;
    end
  end

  for (genvar k = 0; k < CDB_WIDTH; k++) begin : g_lane
    assign cdb_valid[k]                 = lane_v[k];
    assign cdb_prn[k*PRN_W +: PRN_W]    = lane_e[k].prn;
    assign cdb_value[k*DATA_W +: DATA_W] = lane_e[k].value;
    assign cdb_robn[k*ROBN_W +: ROBN_W] = lane_e[k].robn;
  end

  assign stall_count = stall_q;

endmodule

// File: tb/tb_cdb_arbiter_queued.sv
// Scoreboard bench for cdb_arbiter_queued: per-producer expected
// queues filled on drive, drained by a CDB monitor on the negedge.
module tb_cdb_arbiter_queued;

  localparam int NR = 6;
  localparam int CW = 3;
  localparam int DW = 32;
  localparam int PW = 6;
  localparam int RW = 5;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             squash = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*PW-1:0] req_prn = '0;
  logic [NR*DW-1:0] req_value = '0;
  logic [NR*RW-1:0] req_robn = '0;
  logic [NR-1:0]    req_ready;
  logic [CW-1:0]    cdb_valid;
  logic [CW*PW-1:0] cdb_prn;
  logic [CW*DW-1:0] cdb_value;
  logic [CW*RW-1:0] cdb_robn;
  logic [31:0]      stall_count;

  cdb_arbiter_queued #(
    .NUM_REQ(NR), .CDB_WIDTH(CW), .QUEUE_DEPTH(2),
    .DATA_W(DW), .PRN_W(PW), .ROBN_W(RW)
  ) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .req_valid(req_valid), .req_prn(req_prn),
    .req_value(req_value), .req_robn(req_robn),
    .req_ready(req_ready), .cdb_valid(cdb_valid),
    .cdb_prn(cdb_prn), .cdb_value(cdb_value),
    .cdb_robn(cdb_robn), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [PW-1:0] prn;
    logic [DW-1:0] value;
    logic [RW-1:0] robn;
  } item_t;

  item_t pend [NR][$];
  item_t sb   [NR][$];
  bit    shown [NR];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic item_t mk(input int p);
    item_t it;
    it.prn   = PW'(p);
    it.value = 32'hC0DE_0000 + DW'(p * 7);
    it.robn  = RW'(p);
    return it;
  endfunction

  function automatic int sb_total();
    int n = 0;
    for (int i = 0; i < NR; i++) n += sb[i].size() + pend[i].size();
    return n;
  endfunction

  task automatic clear_all();
    for (int i = 0; i < NR; i++) begin
      pend[i].delete();
      sb[i].delete();
      shown[i] = 1'b0;
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NR; i++) begin
      if (pend[i].size() > 0) begin
        if (!shown[i]) begin
          sb[i].push_back(pend[i][0]);
          shown[i] = 1'b1;
        end
        req_valid[i]            = 1'b1;
        req_prn[i*PW +: PW]     = pend[i][0].prn;
        req_value[i*DW +: DW]   = pend[i][0].value;
        req_robn[i*RW +: RW]    = pend[i][0].robn;
      end else begin
        req_valid[i]            = 1'b0;
        req_prn[i*PW +: PW]     = '0;
        req_value[i*DW +: DW]   = '0;
        req_robn[i*RW +: RW]    = '0;
      end
    end
  endtask

  task automatic tick();
    logic [NR-1:0] acc;
    acc = (reset && !squash) ? (req_valid & req_ready) : '0;
    @(posedge clock);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        pend[i].delete(0);
        shown[i] = 1'b0;
      end
    end
    drive_inputs();
  endtask

  task automatic do_reset();
    reset  = 1'b0;
    squash = 1'b0;
    clear_all();
    drive_inputs();
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic drain(input string tag);
    for (int c = 0; c < 80; c++) begin
      if (sb_total() == 0) break;
      tick();
    end
    chk({tag, "_drain"}, sb_total(), 0);
  endtask

  // Monitor: every valid lane must match the head of some producer.
  always @(negedge clock) begin
    for (int k = 0; k < CW; k++) begin
      if (cdb_valid[k] === 1'b1) begin
        bit found;
        found = 1'b0;
        for (int s = 0; s < NR; s++) begin
          if (!found && sb[s].size() > 0 &&
              sb[s][0].prn == cdb_prn[k*PW +: PW]) begin
            chk("cdb_value", cdb_value[k*DW +: DW], sb[s][0].value);
            chk("cdb_robn", cdb_robn[k*RW +: RW], sb[s][0].robn);
            sb[s].delete(0);
            found = 1'b1;
          end
        end
        if (!found) chk("cdb_unexp_prn", {1'b1, cdb_prn[k*PW +: PW]}, 0);
      end else begin
        chk("cdb_idle", {cdb_valid[k], cdb_prn[k*PW +: PW],
                         cdb_value[k*DW +: DW], cdb_robn[k*RW +: RW]}, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clear_all();
    drive_inputs();
    reset = 1'b0;
    tick();
    tick();
    chk("rst_valid", cdb_valid, 0);
    chk("rst_prn", cdb_prn, 0);
    chk("rst_value", cdb_value, 0);
    chk("rst_robn", cdb_robn, 0);
    chk("rst_ready", req_ready, 6'h3f);
    chk("rst_stall", stall_count, 0);
    reset = 1'b1;

    pend[2].push_back('{prn: 6'd5, value: 32'h2A, robn: 5'd7});
    drive_inputs();
    tick();
    chk("t2_valid", cdb_valid, 3'b001);
    chk("t2_prn", cdb_prn, {12'h0, 6'd5});
    chk("t2_value", cdb_value, {64'h0, 32'h2A});
    chk("t2_robn", cdb_robn, {10'h0, 5'd7});
    tick();
    chk("t2_idle", cdb_valid, 0);

    do_reset();
    for (int i = 0; i < NR; i++) pend[i].push_back(mk(i + 1));
    drive_inputs();
    tick();
    chk("t3_c1_valid", cdb_valid, 3'b111);
    chk("t3_c1_prn", cdb_prn, {6'd3, 6'd2, 6'd1});
    tick();
    chk("t3_c2_prn", cdb_prn, {6'd6, 6'd5, 6'd4});
    chk("t3_c2_stall", stall_count, 1);
    tick();
    chk("t3_c3_valid", cdb_valid, 0);
    chk("t3_c3_stall", stall_count, 1);
    pend[5].push_back(mk(30));
    pend[0].push_back(mk(31));
    drive_inputs();
    tick();
    chk("t3_rr_lane0", cdb_prn[0 +: PW], 31);
    chk("t3_rr_lane1", cdb_prn[PW +: PW], 30);
    drain("t3");

    do_reset();
    for (int i = 1; i < NR; i++)
      for (int s = 0; s < 4; s++) pend[i].push_back(mk(16 + 8 * (i - 1) + s));
    drive_inputs();
    tick();
    tick();
    pend[0].push_back(mk(10));
    pend[0].push_back(mk(11));
    pend[0].push_back(mk(12));
    drive_inputs();
    chk("t4_rdy_c2", req_ready[0], 1);
    tick();
    chk("t4_rdy_c3", req_ready[0], 1);
    tick();
    chk("t4_rdy_full", req_ready[0], 0);
    tick();
    chk("t4_rdy_c5", req_ready[0], 1);
    drain("t4");

    do_reset();
    for (int i = 0; i < NR; i++)
      for (int s = 0; s < 7; s++) pend[i].push_back(mk(8 * i + s + 1));
    drive_inputs();
    for (int c = 1; c <= 8; c++) begin
      int base;
      tick();
      base = (c % 2 == 1) ? 0 : 3;
      chk("t5_valid", cdb_valid, 3'b111);
      for (int k = 0; k < CW; k++)
        chk("t5_lane_src", cdb_prn[k*PW +: PW] >> 3, base + k);
    end
    drain("t5");

    do_reset();
    for (int i = 0; i < NR; i++)
      for (int s = 0; s < 5; s++) pend[i].push_back(mk(8 * i + s + 1));
    drive_inputs();
    tick();
    tick();
    tick();
    chk("t6_stall_pre", stall_count, 2);
    squash = 1'b1;
    tick();
    squash = 1'b0;
    clear_all();
    drive_inputs();
    chk("t6_valid", cdb_valid, 0);
    chk("t6_ready", req_ready, 6'h3f);
    chk("t6_stall_hold", stall_count, 2);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t6_quiet", cdb_valid, 0);
    end
    pend[4].push_back(mk(60));
    pend[0].push_back(mk(61));
    drive_inputs();
    tick();
    chk("t6_rr_lane0", cdb_prn[0 +: PW], 61);
    chk("t6_rr_lane1", cdb_prn[PW +: PW], 60);
    drain("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
